uart_rx_sampler: RTL

UART receive front end for the AES256 UART datapath. Converts the asynchronous `rx` pin into validated bytes, one `new_data` pulse per byte, for the byte-collection logic that assembles the 256-bit key and the 128-bit plaintext. The block provides:

- input synchronisation;
- mid-bit sampling with start-bit glitch rejection;
- framing-error detection and break handling.

---
 rtl/uart_rx_sampler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - UART 8N1 receive front end with mid-bit sampling, glitch rejection and break handling (optional UART_RX_MAJORITY_EN)
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       new_data,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

`ifdef UART_RX_MAJORITY_EN
    // Decisions wait one extra cycle so the +1 neighbour of the sample point is visible.
    localparam int SAMPLE_OFF = 1;
`else
    localparam int SAMPLE_OFF = 0;
`endif

    localparam logic [CW-1:0] START_LAST = CW'(HALF - 1 + SAMPLE_OFF);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q;
    logic            rx_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            new_data_q, new_data_d;
    logic            frame_err_q, frame_err_d;
    logic            sample;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s    <= sync1_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1_q, rx_d2_q;

    // History of the synchronised line: d1 holds the sample point, d2 the cycle before it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_d1_q <= 1'b1;
            rx_d2_q <= 1'b1;
        end else begin
            rx_d1_q <= rx_s;
            rx_d2_q <= rx_d1_q;
        end
    end

    // 2-of-3 vote over sample point -1, 0 and +1.
    always_comb begin
        sample = (rx_s & rx_d1_q) | (rx_s & rx_d2_q) | (rx_d1_q & rx_d2_q);
    end
`else
    // Single sample at the sample point.
    always_comb begin
        sample = rx_s;
    end
`endif

    // Receiver state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            new_data_q  <= new_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: walk start, eight data bits and stop; a low stop bit parks in BRK.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        new_data_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    state_d = sample ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (sample) begin
                        data_d     = shift_q;
                        new_data_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BRK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BRK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign new_data  = new_data_q;
    assign frame_err = frame_err_q;
    assign data      = data_q;
    assign busy      = (state_q != IDLE);

endmodule
